alu_mw_sequencer: RTL and testbench

Multi-word sequencer that sits directly upstream of the combinational 8-bit `ALU`. It accepts a wide subtract or compare request over a valid/ready handshake and feeds the ALU one `BITS`-wide slice per cycle, LSB slice first. Borrow is chained through the ALU's `i_carry`/`o_carry` pair, and the wide result is assembled in a register. The result and flags are presented to the downstream consumer with their own valid/ready handshake.

---
 rtl/alu_mw_pkg.sv | 23 ++
 rtl/alu_mw_slice_sel.sv | 31 +++
 rtl/alu_mw_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_mw_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mw_pkg.sv
// alu_mw_pkg
//   Shared types and default sizes for the multi-word subtract/compare
//   sequencer (alu_mw_sequencer) and its slice selector.
//   - state_t : sequencer FSM states
//   - op_t    : request opcode (SUB / CMP)
//   - DEFAULT_BITS / DEFAULT_WORDS : default slice width and slice count
package alu_mw_pkg;

  localparam int DEFAULT_BITS  = 8;
  localparam int DEFAULT_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic {
    OP_SUB = 1'b0,
    OP_CMP = 1'b1
  } op_t;

endpackage

// File: rtl/alu_mw_slice_sel.sv
// alu_mw_slice_sel
//   Combinational selector returning slice 'idx' (BITS wide) of a
//   BITS*WORDS wide vector. Out-of-range indices return 0.
//   Ports:
//     vec   in  BITS*WORDS  source vector
//     idx   in  IDX_W       slice index, 0 = least significant slice
//     slice out BITS        selected slice
module alu_mw_slice_sel
  import alu_mw_pkg::*;
#(
  parameter int BITS  = DEFAULT_BITS,
  parameter int WORDS = DEFAULT_WORDS,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic [BITS*WORDS-1:0] vec,
  input  logic [IDX_W-1:0]      idx,
  output logic [BITS-1:0]       slice
);

  // Explicit compare-per-slice mux keeps every select in range even when
  // WORDS is not a power of two.
  always_comb begin
    slice = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == IDX_W'(w)) begin
        slice = vec[w*BITS +: BITS];
      end
    end
  end

endmodule

// File: rtl/alu_mw_sequencer.sv
// alu_mw_sequencer
//   Feeds a combinational BITS-wide ALU one slice per cycle (LSB first) to
//   compute A - B - carry over BITS*WORDS bits. Borrow is chained through
//   the ALU carry pair; the wide result and flags are held in DONE until the
//   consumer takes them.
//   Optional feature macro: ALU_MW_OVF_EN adds o_ovf (signed overflow).
//   Ports:
//     i_clk, i_rst_n              clock, asynchronous active-low reset
//     i_valid / o_ready           request handshake
//     i_op, i_a, i_b, i_carry     opcode (0 SUB, 1 CMP), operands, borrow-in
//     o_alu_a, o_alu_b, o_alu_carry   current slice towards the ALU
//     i_alu_sub, i_alu_carry      ALU difference and borrow-out
//     o_valid / i_ready           result handshake
//     o_result, o_carry, o_zero, o_op  result, final borrow, all-zero, opcode
//     o_ovf (ALU_MW_OVF_EN only)  two's-complement overflow
module alu_mw_sequencer
  import alu_mw_pkg::*;
#(
  parameter int BITS  = DEFAULT_BITS,
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_op,
  input  logic [BITS*WORDS-1:0] i_a,
  input  logic [BITS*WORDS-1:0] i_b,
  input  logic                  i_carry,
  output logic [BITS-1:0]       o_alu_a,
  output logic [BITS-1:0]       o_alu_b,
  output logic                  o_alu_carry,
  input  logic [BITS-1:0]       i_alu_sub,
  input  logic                  i_alu_carry,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BITS*WORDS-1:0] o_result,
  output logic                  o_carry,
  output logic                  o_zero,
  output logic                  o_op
`ifdef ALU_MW_OVF_EN
  ,
  output logic                  o_ovf
`endif
);

  localparam int W     = BITS * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, b_reg, result_reg, result_next;
  op_t              op_reg;
  logic             borrow_reg;
  logic             zero_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [BITS-1:0]  a_slice, b_slice;
  logic             accept, step, last;

  alu_mw_slice_sel #(.BITS(BITS), .WORDS(WORDS), .IDX_W(IDX_W)) u_sel_a (
    .vec   (a_reg),
    .idx   (idx_reg),
    .slice (a_slice)
  );

  alu_mw_slice_sel #(.BITS(BITS), .WORDS(WORDS), .IDX_W(IDX_W)) u_sel_b (
    .vec   (b_reg),
    .idx   (idx_reg),
    .slice (b_slice)
  );

  assign accept = (state_reg == IDLE) && i_valid;
  assign step   = (state_reg == RUN);
  assign last   = (idx_reg == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake / ALU-facing outputs. o_ready is gated with
  // the reset input so it reads 0 for the whole time reset is held.
  always_comb begin
    state_next  = state_reg;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_alu_a     = '0;
    o_alu_b     = '0;
    o_alu_carry = 1'b0;
    case (state_reg)
      IDLE: begin
        o_ready = i_rst_n;
        if (i_valid) state_next = RUN;
      end
      RUN: begin
        o_alu_a     = a_slice;
        o_alu_b     = b_slice;
        o_alu_carry = borrow_reg;
        if (last) state_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write the ALU difference into the slice currently being processed.
  always_comb begin
    result_next = result_reg;
    for (int w = 0; w < WORDS; w++) begin
      if (step && (idx_reg == IDX_W'(w))) begin
        result_next[w*BITS +: BITS] = i_alu_sub;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      op_reg     <= OP_SUB;
      borrow_reg <= 1'b0;
      zero_reg   <= 1'b0;
      idx_reg    <= '0;
    end else if (accept) begin
      a_reg      <= i_a;
      b_reg      <= i_b;
      op_reg     <= op_t'(i_op);
      borrow_reg <= i_carry;
      zero_reg   <= 1'b1;
      idx_reg    <= '0;
    end else if (step) begin
      result_reg <= result_next;
      borrow_reg <= i_alu_carry;
      zero_reg   <= zero_reg && (i_alu_sub == '0);
      idx_reg    <= idx_reg + 1'b1;
    end
  end

`ifdef ALU_MW_OVF_EN
  logic ovf_reg;

  // Overflow is decided on the top slice: operands of differing sign whose
  // difference takes the sign of B.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_reg <= 1'b0;
    end else if (accept) begin
      ovf_reg <= 1'b0;
    end else if (step && last) begin
      ovf_reg <= (a_reg[W-1] != b_reg[W-1]) && (i_alu_sub[BITS-1] != a_reg[W-1]);
    end
  end

  assign o_ovf = ovf_reg;
`endif

  assign o_result = result_reg;
  assign o_carry  = borrow_reg;
  assign o_zero   = zero_reg;
  assign o_op     = op_reg;

endmodule

// File: tb/tb_alu_mw_sequencer.sv
// tb_alu_mw_sequencer
//   Directed bench for alu_mw_sequencer (BITS=8, WORDS=4) wired to a
//   combinational 8-bit subtract ALU described inline.
module tb_alu_mw_sequencer;

  localparam int BITS  = 8;
  localparam int WORDS = 4;
  localparam int W     = BITS * WORDS;

  logic            i_clk, i_rst_n, i_valid, o_ready, i_op, i_carry;
  logic [W-1:0]    i_a, i_b, o_result;
  logic [BITS-1:0] o_alu_a, o_alu_b, i_alu_sub;
  logic            o_alu_carry, i_alu_carry, o_valid, i_ready;
  logic            o_carry, o_zero, o_op;
`ifdef ALU_MW_OVF_EN
  logic            o_ovf;
`endif

  int checks = 0;
  int errors = 0;

  // ALU: o_out_sub = a - b - carry, o_carry = borrow out of the slice.
  logic [BITS:0] alu_diff;
  assign alu_diff    = {1'b0, o_alu_a} - {1'b0, o_alu_b} - {{BITS{1'b0}}, o_alu_carry};
  assign i_alu_sub   = alu_diff[BITS-1:0];
  assign i_alu_carry = alu_diff[BITS];

  alu_mw_sequencer #(.BITS(BITS), .WORDS(WORDS)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_carry     (i_carry),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_carry (o_alu_carry),
    .i_alu_sub   (i_alu_sub),
    .i_alu_carry (i_alu_carry),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_carry     (o_carry),
    .o_zero      (o_zero),
    .o_op        (o_op)
`ifdef ALU_MW_OVF_EN
    ,
    .o_ovf       (o_ovf)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] res;
    logic        c;
    logic        z;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic present(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_carry = cin;
  endtask

  // Takes the accepting edge, scrambles the inputs, then waits for o_valid.
  // lat counts edges from the accepting edge up to the one raising o_valid,
  // inclusive.
  task automatic accept_and_wait(output int lat);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_a     = ~i_a;
    i_b     = ~i_b;
    i_carry = ~i_carry;
    i_op    = ~i_op;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    $display("txn op=%0d result=%h carry=%0d zero=%0d latency=%0d",
             o_op, o_result, o_carry, o_zero, lat);
  endtask

  task automatic handshake();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check("valid_drop", {31'd0, o_valid}, 32'd0);
    check("ready_back", {31'd0, o_ready}, 32'd1);
  endtask

  int lat;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0005, 32'h0001_0000, 1'b0, 32'hFFFF_0005, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hCC79_6877, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};

    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_op    = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_carry = 1'b0;
    #3 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ready_low", {31'd0, o_ready}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_flags", {29'd0, o_carry, o_zero, o_op}, 32'd0);
    check("rst_alu", {15'd0, o_alu_carry, o_alu_a, o_alu_b}, 32'd0);
    i_rst_n = 1'b1;
    #1;
    check("rst_ready_rel", {31'd0, o_ready}, 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      present(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      accept_and_wait(lat);
      check($sformatf("v%0d_latency", i), lat, 32'd5);
      check($sformatf("v%0d_result", i), o_result, vecs[i].res);
      check($sformatf("v%0d_carry", i), {31'd0, o_carry}, {31'd0, vecs[i].c});
      check($sformatf("v%0d_zero", i), {31'd0, o_zero}, {31'd0, vecs[i].z});
      check($sformatf("v%0d_op", i), {31'd0, o_op}, {31'd0, vecs[i].op});
      handshake();
    end

    // Backpressure: DONE held with a new request pending.
    present(1'b0, 32'h0000_0010, 32'h0000_0001, 1'b0);
    accept_and_wait(lat);
    check("bp_result", o_result, 32'h0000_000F);
    present(1'b1, 32'hAAAA_0000, 32'h0000_0001, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      check("bp_valid_hold", {31'd0, o_valid}, 32'd1);
      check("bp_ready_low", {31'd0, o_ready}, 32'd0);
      check("bp_result_hold", o_result, 32'h0000_000F);
      check("bp_op_hold", {31'd0, o_op}, 32'd0);
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check("bp_idle_ready", {31'd0, o_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, o_valid}, 32'd0);
    accept_and_wait(lat);
    check("bp2_latency", lat, 32'd5);
    check("bp2_result", o_result, 32'hAAA9_FFFF);
    check("bp2_op", {31'd0, o_op}, 32'd1);
    handshake();

    // Reset while RUN is on slice 2.
    present(1'b0, 32'h0102_0304, 32'h0000_0000, 1'b0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (2) begin
      @(posedge i_clk); #1;
    end
    check("run_slice2_a", {24'd0, o_alu_a}, 32'h0000_0002);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, o_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_result", o_result, 32'd0);
    check("mid_rst_flags", {29'd0, o_carry, o_zero, o_op}, 32'd0);
    check("mid_rst_alu", {15'd0, o_alu_carry, o_alu_a, o_alu_b}, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    #1;
    check("mid_rst_ready_rel", {31'd0, o_ready}, 32'd1);
    present(1'b0, 32'h0000_0002, 32'h0000_0001, 1'b0);
    accept_and_wait(lat);
    check("post_rst_latency", lat, 32'd5);
    check("post_rst_result", o_result, 32'h0000_0001);
    check("post_rst_carry", {31'd0, o_carry}, 32'd0);
    handshake();

`ifdef ALU_MW_OVF_EN
    present(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0);
    accept_and_wait(lat);
    check("ovf1_result", o_result, 32'h7FFF_FFFF);
    check("ovf1_ovf", {31'd0, o_ovf}, 32'd1);
    check("ovf1_carry", {31'd0, o_carry}, 32'd0);
    handshake();
    present(1'b0, 32'h0000_0003, 32'h0000_0001, 1'b0);
    accept_and_wait(lat);
    check("ovf2_result", o_result, 32'h0000_0002);
    check("ovf2_ovf", {31'd0, o_ovf}, 32'd0);
    handshake();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
